// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Purpose  : Request/response bus between the CPU memory-access stage
//            (master) and the data-memory controller (slave).
// Signals  : req_valid/req_ready    request handshake
//            req_we                 1 = store, 0 = load
//            req_size               00 byte, 01 half, 10 word, 11 illegal
//            req_unsigned           zero-extend loads when set
//            req_addr/req_wdata     byte address / right-justified store data
//            resp_valid             one-cycle completion pulse
//            resp_rdata/resp_err    load result / error flag, qualified by
//                                   resp_valid
//            busy                   controller is in BUSY or RESP
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Data-memory controller for lw/lh/lb/lbu/lhu/sw/sh/sb. Owns a
//            word-organised little-endian RAM, accepts one request at a time
//            via valid/ready and answers after a programmable latency.
//            Misaligned, out-of-range and illegal-size requests are answered
//            with resp_err and never touch the RAM.
// Ports    : clk    rising-edge clock
//            reset  synchronous, active-low (0 = reset)
//            bus    data_mem_ctrl_if.slave (request/response bus)
// Params   : MEM_DEPTH  RAM depth in 32-bit words (power of two, >= 2)
//            LATENCY    cycles spent in BUSY per access (1..15)
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 1
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);

  localparam int c_aw = $clog2(MEM_DEPTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;
  localparam logic [1:0] c_sz_bad  = 2'b11;

  localparam logic [3:0] c_lat_m1  = 4'(LATENCY - 1);

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q,   cnt_d;
  logic            we_q,    we_d;
  logic [1:0]      size_q,  size_d;
  logic            uns_q,   uns_d;
  logic [c_aw-1:0] idx_q,   idx_d;
  logic [1:0]      off_q,   off_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q,   err_d;

  logic [31:0]     mem_q [MEM_DEPTH];

  // --------------------------------------------------------------------------
  // Request classification (evaluated on the live request in IDLE)
  // --------------------------------------------------------------------------
  logic w_misalign;
  logic w_illegal;
  logic w_out_of_range;
  logic w_req_err;

  assign w_misalign = ((bus.req_size == c_sz_half) && bus.req_addr[0]) ||
                      ((bus.req_size == c_sz_word) && (bus.req_addr[1:0] != 2'b00));
  assign w_illegal  = (bus.req_size == c_sz_bad);
  // Compare the full word address so addresses above the RAM never alias.
  assign w_out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_DEPTH));
  assign w_req_err  = w_misalign || w_illegal || w_out_of_range;

  // --------------------------------------------------------------------------
  // Access datapath
  // --------------------------------------------------------------------------
  logic        w_do_access;
  logic [31:0] w_rword;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;

  assign w_do_access = (state_q == c_st_busy) && (cnt_q == 4'd0);
  assign w_rword     = mem_q[idx_q];
  // Bring the addressed byte/half down to bit 0. Legal halves have off[0]=0,
  // so the byte shift also serves half-word loads.
  assign w_shifted   = w_rword >> {off_q, 3'b000};

  always_comb begin
    w_load_ext = w_rword;
    case (size_q)
      c_sz_byte: w_load_ext = {{24{~uns_q & w_shifted[7]}},  w_shifted[7:0]};
      c_sz_half: w_load_ext = {{16{~uns_q & w_shifted[15]}}, w_shifted[15:0]};
      default:   w_load_ext = w_rword;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lanes.
  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = wdata_q;
    case (size_q)
      c_sz_byte: begin
        w_be     = 4'b0001 << off_q;
        w_wlanes = {4{wdata_q[7:0]}};
      end
      c_sz_half: begin
        w_be     = off_q[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{wdata_q[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = wdata_q;
      end
    endcase
  end

  // RAM contents survive reset; a store is only committed on its final BUSY
  // edge while reset is released, so an aborted store leaves the RAM intact.
  always_ff @(posedge clk) begin
    if (reset && w_do_access && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[idx_q][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      c_st_idle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          idx_d   = bus.req_addr[c_aw+1:2];
          off_d   = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          if (w_req_err) begin
            // Rejected requests skip BUSY entirely.
            state_d = c_st_resp;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            state_d = c_st_busy;
            cnt_d   = c_lat_m1;
          end
        end
      end

      c_st_busy: begin
        if (cnt_q == 4'd0) begin
          state_d = c_st_resp;
          rdata_d = we_q ? 32'd0 : w_load_ext;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      c_st_resp: begin
        state_d = c_st_idle;
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= c_sz_byte;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (state_q == c_st_idle);
  assign bus.resp_valid = (state_q == c_st_resp);
  assign bus.busy       = (state_q != c_st_idle);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Bench for data_mem_ctrl. Two instances (LATENCY=1 and
//            LATENCY=3) share clock and reset; one is selected at a time.
//            A byte-addressed reference memory with a cycle countdown
//            predicts ready/busy/valid/rdata/err every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int DEPTH  = 64;
  localparam int NBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;          // 0: LATENCY=1 instance, 1: LATENCY=3 instance
  logic        d_valid;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_uns;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  int errors = 0;
  int checks = 0;
  logic chk_en;

  data_mem_ctrl_if if1 ();
  data_mem_ctrl_if if3 ();

  assign if1.req_valid    = d_valid && (sel == 1'b0);
  assign if1.req_we       = d_we;
  assign if1.req_size     = d_size;
  assign if1.req_unsigned = d_uns;
  assign if1.req_addr     = d_addr;
  assign if1.req_wdata    = d_wdata;

  assign if3.req_valid    = d_valid && (sel == 1'b1);
  assign if3.req_we       = d_we;
  assign if3.req_size     = d_size;
  assign if3.req_unsigned = d_uns;
  assign if3.req_addr     = d_addr;
  assign if3.req_wdata    = d_wdata;

  data_mem_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  data_mem_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  logic        w_ready, w_rvalid, w_err, w_busy;
  logic [31:0] w_rdata;
  assign w_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign w_rvalid = sel ? if3.resp_valid : if1.resp_valid;
  assign w_err    = sel ? if3.resp_err   : if1.resp_err;
  assign w_busy   = sel ? if3.busy       : if1.busy;
  assign w_rdata  = sel ? if3.resp_rdata : if1.resp_rdata;

  // --------------------------------------------------------------------------
  // Reference model: byte memory per instance, plus "cycles until idle".
  // phase==0 idle, phase==1 response cycle, phase>1 still working.
  // --------------------------------------------------------------------------
  logic [7:0]  mbytes [2][NBYTES];
  int          phase;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        p_we;
  logic [1:0]  p_size;
  logic        p_uns;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = size_bytes(sz);
    return (sz == 2'd3) || ((a % 32'(nb)) != 32'd0) || (a >= 32'(NBYTES));
  endfunction

  function automatic logic [31:0] load_val(input logic s, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
    logic [31:0] v;
    int nb;
    int idx;
    nb = size_bytes(sz);
    v  = 32'd0;
    for (int i = 0; i < nb; i++) begin
      idx = int'(a) + i;
      v[8*i +: 8] = mbytes[s][idx];
    end
    if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      phase   <= 0;
      m_rdata <= 32'd0;
      m_err   <= 1'b0;
    end else if (phase == 0) begin
      if (d_valid) begin
        p_we    <= d_we;
        p_size  <= d_size;
        p_uns   <= d_uns;
        p_addr  <= d_addr;
        p_wdata <= d_wdata;
        if (is_bad(d_size, d_addr)) begin
          phase   <= 1;
          m_rdata <= 32'd0;
          m_err   <= 1'b1;
        end else begin
          phase <= (sel ? 3 : 1) + 1;
        end
      end
    end else begin
      phase <= phase - 1;
      if (phase == 2) begin
        m_err <= 1'b0;
        if (p_we) begin
          m_rdata <= 32'd0;
          for (int i = 0; i < 4; i++) begin
            if (i < size_bytes(p_size)) mbytes[sel][int'(p_addr) + i] <= p_wdata[8*i +: 8];
          end
        end else begin
          m_rdata <= load_val(sel, p_size, p_uns, p_addr);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (chk_en) begin
      chk("req_ready",  32'(w_ready),  32'(phase == 0));
      chk("busy",       32'(w_busy),   32'(phase != 0));
      chk("resp_valid", 32'(w_rvalid), 32'(phase == 1));
      chk("resp_err",   32'(w_err),    32'(m_err));
      chk("resp_rdata", w_rdata,       m_rdata);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle and wait (bounded) for its response.
  // lat counts cycles from acceptance: cycle right after the accepting edge = 1.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic hold,
                        output logic [31:0] rd, output logic e,
                        output int lat, output int nbusy);
    logic got;
    d_valid = 1'b1;
    d_we    = we;
    d_size  = sz;
    d_uns   = u;
    d_addr  = a;
    d_wdata = wd;
    tick();
    if (!hold) d_valid = 1'b0;
    got = 1'b0; lat = 0; nbusy = 0; rd = 32'd0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      compare();
      if (w_busy) nbusy++;
      if (w_rvalid) begin
        got = 1'b1; rd = w_rdata; e = w_err; lat = n;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    d_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response expected resp_valid within 40 cycles addr %h", a);
    end
  endtask

  task automatic init_mem();
    logic [31:0] rd; logic e; int lat; int nb;
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b1, 2'd2, 1'b0, 32'(4*w), $urandom, 1'b0, rd, e, lat, nb);
    end
  endtask

  task automatic random_run(input int count);
    logic [31:0] rd; logic e; int lat; int nb;
    logic [1:0]  sz;
    logic [31:0] a;
    int k;
    for (int n = 0; n < count; n++) begin
      sz = ($urandom_range(0, 99) < 5) ? 2'd3 : 2'($urandom_range(0, 2));
      k  = $urandom_range(0, 99);
      if (k < 5)       a = 32'(NBYTES) + 32'($urandom_range(0, 1000));
      else if (k < 8)  a = $urandom;
      else             a = 32'($urandom_range(0, NBYTES - 1));
      if (k >= 20) a = a & ~(32'(size_bytes(sz)) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 3) == 0), rd, e, lat, nb);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic reset_select(input logic s);
    chk_en = 1'b0;
    reset  = 1'b0;
    sel    = s;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    reset  = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : main
    logic [31:0] rd; logic e; int lat; int nb;
    reset = 1'b0; sel = 1'b0; chk_en = 1'b0;
    d_valid = 1'b0; d_we = 1'b0; d_size = 2'd0; d_uns = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    chk("reset_ready", 32'(w_ready), 32'd1);
    chk("reset_rdata", w_rdata, 32'd0);
    reset = 1'b1;

    // ---- LATENCY = 1 instance ----
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h0000_1234, 1'b0, rd, e, lat, nb);
    chk("sw_lat", 32'(lat), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lw0_data", rd, 32'h0000_1234);
    chk("lw0_err",  32'(e), 32'd0);
    chk("lw0_lat",  32'(lat), 32'd2);

    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, 1'b0, rd, e, lat, nb);
    do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_0080, 1'b0, rd, e, lat, nb);
    do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lb5",  rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lbu5", rd, 32'h0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lw4",  rd, 32'h1122_8044);
    do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lh6",  rd, 32'h0000_1122);

    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0, rd, e, lat, nb);
    chk("lw2_err", 32'(e), 32'd1);
    chk("lw2_lat", 32'(lat), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF, 1'b0, rd, e, lat, nb);
    chk("sh3_err", 32'(e), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, rd, e, lat, nb);
    chk("sz3_err", 32'(e), 32'd1);
    chk("sz3_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0, 1'b0, rd, e, lat, nb);
    chk("oor_err", 32'(e), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hBAD0_BAD0, 1'b0, rd, e, lat, nb);
    chk("oor_sw_err", 32'(e), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, rd, e, lat, nb);
    chk("lw0_after_err", rd, 32'h0000_1234);

    init_mem();
    random_run(250);

    // ---- LATENCY = 3 instance ----
    reset_select(1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b0, rd, e, lat, nb);
    chk("l3_sw_lat",  32'(lat), 32'd4);
    chk("l3_sw_busy", 32'(nb),  32'd4);

    d_valid = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h8; d_wdata = 32'hCAFE_F00D;
    tick();
    d_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("abort_busy",  32'(w_busy),  32'd0);
    chk("abort_ready", 32'(w_ready), 32'd1);
    reset = 1'b1;
    tick();
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, rd, e, lat, nb);
    chk("abort_lw8", rd, 32'hDEAD_BEEF);

    init_mem();
    random_run(120);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller sitting directly downstream of the CPU's memory-access stage; services lw/lh/lb/lbu/lhu/sw/sh/sb requests. Owns a word-organised data RAM, little-endian. Uses a valid/ready request handshake and a programmable access latency, so both single_cycle_cpu (LATENCY=1) and multi_cycle_cpu can stall on it. Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in the data RAM (power of two)
LATENCY, 1, cycles spent in BUSY per access; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  single-cycle pulse: access complete
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal size
busy  output  1  1 in BUSY or RESP states

Behaviour:
- States: IDLE, BUSY, RESP. Reset (reset==0 at a rising edge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0. RAM contents are not reset.
- IDLE: req_ready=1. Handshake = req_valid && req_ready at a rising edge; all req_* fields latched.
- Error check at acceptance: misaligned (half with addr[0]=1; word with addr[1:0]!=0), req_size==11, or addr[31:2] >= MEM_DEPTH -> go straight to RESP with resp_err=1, resp_rdata=0; no RAM write ever occurs.
- Legal request -> BUSY, counter loaded with LATENCY-1; req_ready=0.
- BUSY: counter decrements each cycle; on the edge where counter==0, the access is performed: store writes only the addressed byte lanes (byte: lane addr[1:0]; half: lanes {addr[1],0} and {addr[1],1}; word: all four), load captures and extends data; then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; next edge -> IDLE. No response backpressure; consumer must sample in that cycle.
- Latency: request accepted at edge E0 -> resp_valid high during cycle after edge E0+LATENCY, i.e. LATENCY+1 cycles request-to-response; back-to-back throughput one access per LATENCY+2 cycles. Error path: resp_valid in the cycle after E0.
- Load extension: byte -> bit 7 replicated (or zeros if req_unsigned); half -> bit 15 replicated (or zeros); word unaffected; req_unsigned ignored for stores and words.
- resp_rdata/resp_err hold their last values outside RESP; only resp_valid qualifies them.
- req_valid while not IDLE is ignored; no request is queued.
- Reset mid-operation: abort immediately, return to IDLE; a store still in BUSY when reset asserts before its final edge is discarded (RAM unchanged).
- Load and store of the same address in consecutive requests: the load returns the newly stored data.
- Word index = req_addr[$clog2(MEM_DEPTH)+1:2].

Test Plan:
- LATENCY=1: sw 0x00001234 to 0x0, then lw 0x0 -> resp_rdata=0x00001234, resp_err=0, resp_valid 2 cycles after each acceptance, one cycle wide.
- sw 0x11223344 to 0x4; sb 0x80 to 0x5; lb 0x5 -> 0xFFFFFF80; lbu 0x5 -> 0x00000080; lw 0x4 -> 0x11228044; lh 0x6 -> 0x00001122.
- lw 0x2, sh 0x3, size=11 -> each resp_err=1, resp_rdata=0, resp_valid in the cycle after acceptance; following lw 0x0 unchanged.
- lw at byte address 4*MEM_DEPTH -> resp_err=1, no write; req_valid held high during BUSY -> req_ready=0, only one response produced.
- LATENCY=3: sw 0xDEADBEEF to 0x8, accepted at edge E0 -> resp_valid during cycle after E0+3; busy=1 for 4 cycles.
- LATENCY=3: sw 0xCAFEF00D to 0x8 (old 0xDEADBEEF), assert reset after 1 BUSY cycle -> outputs at reset values next cycle, later lw 0x8 returns 0xDEADBEEF.
